// File: rtl/arb_grant_data_mux.sv
// arb_grant_data_mux: captures one-hot arbiter grants with their payloads into a 2-entry FIFO
module arb_grant_data_mux #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    grant,
  input  logic [N*DW-1:0] req_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  output logic [SW-1:0]   out_src,
  output logic [N-1:0]    ack,
  output logic [N-1:0]    nack,
  output logic            grant_err
);
  logic [1:0]    count_q, count_d;
  logic          wp_q, wp_d, rp_q, rp_d;
  logic [DW-1:0] data_q [2];
  logic [DW-1:0] data_d [2];
  logic [SW-1:0] src_q [2];
  logic [SW-1:0] src_d [2];
  logic [N-1:0]  ack_q, ack_d, nack_q, nack_d;
  logic          err_q, err_d;
  logic          onehot, multi, push, pop;
  logic [SW-1:0] idx;
  logic [DW-1:0] sel;
  assign out_valid = count_q != 2'd0;
  assign out_data  = data_q[rp_q];
  assign out_src   = src_q[rp_q];
  assign ack       = ack_q;
  assign nack      = nack_q;
  assign grant_err = err_q;
  // encode the granted client and pick its payload slice
  always_comb begin
    idx = '0;
    sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        idx = SW'(i);
        sel = req_data[i*DW +: DW];
      end
    end
  end
  // FIFO bookkeeping, handshake pulses and sticky multi-hot flag
  always_comb begin
    onehot  = grant != '0 && (grant & (grant - N'(1))) == '0;
    multi   = grant != '0 && !onehot;
    pop     = out_valid && out_ready;
    push    = onehot && (count_q != 2'd2 || pop);
    data_d  = data_q;
    src_d   = src_q;
    if (push) begin
      data_d[wp_q] = sel;
      src_d[wp_q]  = idx;
    end
    wp_d    = wp_q ^ push;
    rp_d    = rp_q ^ pop;
    count_d = count_q + 2'(push) - 2'(pop);
    ack_d   = push ? grant : '0;
    nack_d  = (onehot && !push) ? grant : '0;
    err_d   = err_q | multi;
  end
  // state registers; reset clears everything including the entry storage
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      src_q[0]  <= '0;
      src_q[1]  <= '0;
      ack_q     <= '0;
      nack_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      src_q[0]  <= src_d[0];
      src_q[1]  <= src_d[1];
      ack_q     <= ack_d;
      nack_q    <= nack_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_arb_grant_data_mux.sv
// tb_arb_grant_data_mux: table-driven vectors plus scoreboard of captured entries
module tb_arb_grant_data_mux;
  localparam int N = 4, DW = 32, SW = 2;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b0;
  logic [N-1:0] grant = '0;
  logic [N*DW-1:0] req_data = '0;
  logic out_valid, grant_err;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_src;
  logic [N-1:0] ack, nack;
  typedef struct packed {logic [SW-1:0] src; logic [DW-1:0] data;} ent_t;
  typedef struct {
    logic r; logic [N-1:0] g; logic rdy;
    logic [N-1:0] ea; logic [N-1:0] en; logic ev; logic [SW-1:0] es; logic ee;
  } vec_t;
  ent_t sb[$];
  vec_t vt[22];
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  arb_grant_data_mux #(.N(N), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .grant(grant), .req_data(req_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .ack(ack), .nack(nack), .grant_err(grant_err)
  );
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  // drive one cycle; the scoreboard pops (and compares) on handshake and pushes on accepted grants
  task automatic drive(input logic r, input logic [N-1:0] g, input logic rdy, input logic keep_a5);
    ent_t h;
    int idx;
    bit pop_m, push_m;
    rst = r;
    grant = g;
    out_ready = rdy;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = $urandom;
    if (keep_a5) req_data[2*DW +: DW] = 32'hA5A5A5A5;
    if (r) sb.delete();
    else begin
      pop_m = sb.size() != 0 && rdy;
      push_m = $countones(g) == 1 && (sb.size() < 2 || pop_m);
      if (pop_m) begin
        h = sb.pop_front();
        chk("sb_data", 64'(out_data), 64'(h.data));
        chk("sb_src", 64'(out_src), 64'(h.src));
      end
      if (push_m) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (g[i]) idx = i;
        sb.push_back({SW'(idx), req_data[idx*DW +: DW]});
      end
    end
    @(posedge clk);
    #1;
    chk("sb_valid", 64'(out_valid), 64'(sb.size() != 0));
  endtask
  initial begin
    ent_t h;
    int n;
    //          rst  grant    rdy   ack      nack     val   src    err
    vt[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0};
    vt[2]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0};
    vt[4]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd0, 1'b0};
    vt[5]  = '{1'b0, 4'b1000, 1'b0, 4'b0000, 4'b1000, 1'b1, 2'd0, 1'b0};
    vt[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 1'b0};
    vt[7]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 2'd1, 1'b0};
    vt[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2, 1'b0};
    vt[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[10] = '{1'b0, 4'b0011, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
    vt[11] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b1};
    vt[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b1};
    vt[13] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b1};
    vt[14] = '{1'b0, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd0, 1'b1};
    vt[15] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[16] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    vt[17] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 4'b0000, 1'b1, 2'd0, 1'b0};
    vt[18] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b1, 2'd1, 1'b0};
    vt[19] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 2'd2, 1'b0};
    vt[20] = '{1'b0, 4'b1000, 1'b1, 4'b1000, 4'b0000, 1'b1, 2'd3, 1'b0};
    vt[21] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0};
    for (int k = 0; k < 22; k++) begin
      drive(vt[k].r, vt[k].g, vt[k].rdy, 1'b1);
      chk($sformatf("ack[%0d]", k), 64'(ack), 64'(vt[k].ea));
      chk($sformatf("nack[%0d]", k), 64'(nack), 64'(vt[k].en));
      chk($sformatf("valid[%0d]", k), 64'(out_valid), 64'(vt[k].ev));
      chk($sformatf("err[%0d]", k), 64'(grant_err), 64'(vt[k].ee));
      if (vt[k].ev) chk($sformatf("src[%0d]", k), 64'(out_src), 64'(vt[k].es));
      if (k == 0 || k == 15) begin
        chk($sformatf("rst_data[%0d]", k), 64'(out_data), 64'd0);
        chk($sformatf("rst_src[%0d]", k), 64'(out_src), 64'd0);
      end
      if (k == 1) chk("single_data", 64'(out_data), 64'hA5A5A5A5);
    end
    drive(1'b0, 4'b0001, 1'b0, 1'b0);
    drive(1'b0, 4'b0010, 1'b0, 1'b0);
    h = sb[0];
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 4'b0000, 1'b0, 1'b0);
      chk("hold_data", 64'(out_data), 64'(h.data));
      chk("hold_src", 64'(out_src), 64'(h.src));
      chk("hold_ack", 64'(ack), 64'd0);
    end
    n = 0;
    while (out_valid && n < 10) begin
      drive(1'b0, 4'b0000, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 64'(out_valid), 64'd0);
    chk("drain_sb", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/arb_grant_data_mux.md
ARB_GRANT_DATA_MUX -- requirements
Module: arb_grant_data_mux

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesting clients (N >= 2).
REQ-002 SHALL have parameter DW, default 32, meaning per-client payload width in bits.
REQ-003 SHALL have parameter SW, default $clog2(N), meaning source-index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port grant  input  N  grant pulse from the upstream round-robin arbiter; a valid grant is one-hot.
REQ-007 SHALL have port req_data  input  N*DW  client payloads; client i occupies bits [i*DW +: DW].
REQ-008 SHALL have port out_valid  output  1  FIFO head holds a transaction.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the head.
REQ-010 SHALL have port out_data  output  DW  payload at the FIFO head.
REQ-011 SHALL have port out_src  output  SW  client index at the FIFO head.
REQ-012 SHALL have port ack  output  N  one-cycle pulse to the client whose grant was captured.
REQ-013 SHALL have port nack  output  N  one-cycle pulse to the client whose grant was dropped because the FIFO was full.
REQ-014 SHALL have port grant_err  output  1  sticky flag for a multi-hot grant.

Function
REQ-015 SHALL hold captured transactions in a 2-entry FIFO; each entry is {src index, payload}; occupancy count ranges 0..2.
REQ-016 SHALL treat grant as one-hot when exactly one bit is set, and as idle when grant == 0.
REQ-017 SHALL define pop = out_valid && out_ready.
REQ-018 SHALL define push = grant one-hot && (count < 2 || pop).
REQ-019 SHALL, on push, write {index of the set grant bit, req_data slice of that client} at the tail on the same clock edge the grant is sampled.
REQ-020 SHALL, on push, drive ack = grant in the following cycle for exactly one cycle; ack SHALL be 0 in all other cycles.
REQ-021 SHALL, when grant is one-hot, count == 2 and pop is 0, drop the grant, leave the FIFO unchanged, and drive nack = grant for one cycle in the following cycle.
REQ-022 SHALL, when grant has 2 or more bits set, ignore it (no push, no ack, no nack) and set grant_err to 1 on the next edge; grant_err SHALL stay 1 until rst.
REQ-023 SHALL drive out_valid = (count != 0); out_data and out_src SHALL come directly from head-entry registers, with no combinational path from req_data or grant.
REQ-024 SHALL keep out_data and out_src stable while out_valid = 1 and out_ready = 0.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged, advance the head, and place the new entry behind any remaining entry, preserving FIFO order.
REQ-026 SHALL, on pop with no push, decrement count; on push with no pop, increment count.
REQ-027 SHALL give capture-to-output latency as follows: an entry pushed into an empty FIFO is visible on out_valid/out_data in the next cycle.
REQ-028 SHALL wrap read and write pointers modulo 2.
REQ-029 SHALL, on pop when count == 0, do nothing, since pop cannot occur with out_valid = 0.

Reset
REQ-030 SHALL, while rst = 1 at a clock edge, set count = 0, both pointers = 0, out_valid = 0, ack = 0, nack = 0 and grant_err = 0; out_data and out_src SHALL be 0.
REQ-031 SHALL give rst priority over push and pop in the same cycle; a grant sampled with rst = 1 is discarded with no ack and no nack.
REQ-032 SHALL, on reset asserted mid-operation, discard buffered entries and suppress any pending ack or nack.

Verification
REQ-033 Single grant: N=4, empty FIFO, grant=0100, req_data[2]=0xA5A5A5A5, out_ready=1 -> next cycle ack=0100, out_valid=1, out_data=0xA5A5A5A5, out_src=2; following cycle out_valid=0.
REQ-034 Backpressure/full: out_ready=0, grants 0001, 0010, 1000 on 3 consecutive cycles -> ack for clients 0 and 1, nack=1000 one cycle after the third grant, count=2, head remains client 0.
REQ-035 Full with simultaneous pop: count=2, out_ready=1, grant=0100 -> push accepted, ack=0100, count stays 2, output order is client 1 then client 2.
REQ-036 Multi-hot: grant=0011 -> no ack, no nack, FIFO unchanged, grant_err=1 from the next cycle onward; a later valid grant is still captured normally.
REQ-037 Reset mid-operation: count=2, then rst=1 together with grant=0001 -> next cycle out_valid=0, ack=0, nack=0, grant_err=0.
REQ-038 Streaming: a grant every cycle rotating 0001->0010->0100->1000 with out_ready=1 -> zero nacks, one ack per grant, out_src sequence 0,1,2,3 each one cycle after its grant.
